// File: rtl/l2_output_encoder.sv
// l2_output_encoder
//   Outbound buffering for the L2 core. Each of four channels (req_out, rsp_out,
//   rd_rsp, inval) has an independent 2-entry FIFO. The FIFO is loaded by a
//   single-cycle send strobe and drained over a valid/ready handshake.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   send_*                   per-channel enqueue strobes (any combination)
//   req_* / rsp_* /
//   rd_rsp_line / inval_addr per-channel payload inputs
//   *_full                   channel FIFO holds 2 entries (back-pressure)
//   l2_*_valid/ready/payload registered-FIFO output handshakes
//   out_idle                 all four FIFOs empty
//   overflow_err             sticky: a send arrived while its channel was full

// One 2-entry FIFO channel. No write-to-read bypass: an entry pushed in
// cycle N is first visible in cycle N+1. Storage is not reset.
module l2_oe_fifo #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_req,
   input  logic         ready,
   input  logic [W-1:0] din,
   output logic         valid,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] dout
);
   logic [W-1:0] mem [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic [1:0]   count;
   logic         push;
   logic         pop;

   assign full  = (count == 2'd2);
   assign empty = (count == 2'd0);
   assign valid = !empty;
   // A push into a full FIFO is dropped even if a pop frees a slot this cycle.
   assign push  = push_req && !full;
   assign pop   = valid && ready;
   assign dout  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst) begin
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end
endmodule

module l2_output_encoder #(
   parameter int LINE_ADDR_W = 28,
   parameter int LINE_W      = 128,
   parameter int MSG_W       = 2,
   parameter int REQ_ID_W    = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   send_req,
   input  logic                   send_rsp,
   input  logic                   send_rd_rsp,
   input  logic                   send_inval,
   input  logic [MSG_W-1:0]       req_coh_msg,
   input  logic                   req_hprot,
   input  logic [LINE_ADDR_W-1:0] req_addr,
   input  logic [LINE_W-1:0]      req_line,
   input  logic [MSG_W-1:0]       rsp_coh_msg,
   input  logic [REQ_ID_W-1:0]    rsp_req_id,
   input  logic                   rsp_to_req,
   input  logic [LINE_ADDR_W-1:0] rsp_addr,
   input  logic [LINE_W-1:0]      rsp_line,
   input  logic [LINE_W-1:0]      rd_rsp_line,
   input  logic [LINE_ADDR_W-1:0] inval_addr,
   output logic                   req_full,
   output logic                   rsp_full,
   output logic                   rd_rsp_full,
   output logic                   inval_full,
   output logic                   l2_req_out_valid,
   input  logic                   l2_req_out_ready,
   output logic [MSG_W-1:0]       l2_req_out_coh_msg,
   output logic                   l2_req_out_hprot,
   output logic [LINE_ADDR_W-1:0] l2_req_out_addr,
   output logic [LINE_W-1:0]      l2_req_out_line,
   output logic                   l2_rsp_out_valid,
   input  logic                   l2_rsp_out_ready,
   output logic [MSG_W-1:0]       l2_rsp_out_coh_msg,
   output logic [REQ_ID_W-1:0]    l2_rsp_out_req_id,
   output logic                   l2_rsp_out_to_req,
   output logic [LINE_ADDR_W-1:0] l2_rsp_out_addr,
   output logic [LINE_W-1:0]      l2_rsp_out_line,
   output logic                   l2_rd_rsp_valid,
   input  logic                   l2_rd_rsp_ready,
   output logic [LINE_W-1:0]      l2_rd_rsp_line,
   output logic                   l2_inval_valid,
   input  logic                   l2_inval_ready,
   output logic [LINE_ADDR_W-1:0] l2_inval_addr,
   output logic                   out_idle,
   output logic                   overflow_err
);
   localparam int REQ_W = MSG_W + 1 + LINE_ADDR_W + LINE_W;
   localparam int RSP_W = MSG_W + REQ_ID_W + 1 + LINE_ADDR_W + LINE_W;

   logic [REQ_W-1:0] req_dout;
   logic [RSP_W-1:0] rsp_dout;
   logic req_empty, rsp_empty, rd_rsp_empty, inval_empty;

   l2_oe_fifo #(.W(REQ_W)) u_req (
      .clk(clk), .rst(rst), .push_req(send_req), .ready(l2_req_out_ready),
      .din({req_coh_msg, req_hprot, req_addr, req_line}),
      .valid(l2_req_out_valid), .full(req_full), .empty(req_empty), .dout(req_dout));

   l2_oe_fifo #(.W(RSP_W)) u_rsp (
      .clk(clk), .rst(rst), .push_req(send_rsp), .ready(l2_rsp_out_ready),
      .din({rsp_coh_msg, rsp_req_id, rsp_to_req, rsp_addr, rsp_line}),
      .valid(l2_rsp_out_valid), .full(rsp_full), .empty(rsp_empty), .dout(rsp_dout));

   l2_oe_fifo #(.W(LINE_W)) u_rd_rsp (
      .clk(clk), .rst(rst), .push_req(send_rd_rsp), .ready(l2_rd_rsp_ready),
      .din(rd_rsp_line),
      .valid(l2_rd_rsp_valid), .full(rd_rsp_full), .empty(rd_rsp_empty), .dout(l2_rd_rsp_line));

   l2_oe_fifo #(.W(LINE_ADDR_W)) u_inval (
      .clk(clk), .rst(rst), .push_req(send_inval), .ready(l2_inval_ready),
      .din(inval_addr),
      .valid(l2_inval_valid), .full(inval_full), .empty(inval_empty), .dout(l2_inval_addr));

   assign {l2_req_out_coh_msg, l2_req_out_hprot, l2_req_out_addr, l2_req_out_line} = req_dout;
   assign {l2_rsp_out_coh_msg, l2_rsp_out_req_id, l2_rsp_out_to_req,
           l2_rsp_out_addr, l2_rsp_out_line} = rsp_dout;

   assign out_idle = req_empty && rsp_empty && rd_rsp_empty && inval_empty;

   always_ff @(posedge clk) begin
      if (!rst)
         overflow_err <= 1'b0;
      else if ((send_req && req_full) || (send_rsp && rsp_full) ||
               (send_rd_rsp && rd_rsp_full) || (send_inval && inval_full))
         overflow_err <= 1'b1;
   end
endmodule

// File: tb/tb_l2_output_encoder.sv
// Testbench for l2_output_encoder: directed steps from the test plan followed by
// a randomized phase, all checked against queue-based channel models.
module tb_l2_output_encoder;
   localparam int AW = 28, LW = 128, MW = 2, IW = 4;
   localparam int REQ_W = MW + 1 + AW + LW;
   localparam int RSP_W = MW + IW + 1 + AW + LW;

   logic clk = 1'b0;
   logic rst;
   logic send_req, send_rsp, send_rd_rsp, send_inval;
   logic [MW-1:0] req_coh_msg;  logic req_hprot;
   logic [AW-1:0] req_addr;     logic [LW-1:0] req_line;
   logic [MW-1:0] rsp_coh_msg;  logic [IW-1:0] rsp_req_id; logic rsp_to_req;
   logic [AW-1:0] rsp_addr;     logic [LW-1:0] rsp_line;
   logic [LW-1:0] rd_rsp_line;  logic [AW-1:0] inval_addr;
   logic req_full, rsp_full, rd_rsp_full, inval_full;
   logic l2_req_out_valid, l2_req_out_ready;
   logic [MW-1:0] l2_req_out_coh_msg; logic l2_req_out_hprot;
   logic [AW-1:0] l2_req_out_addr;    logic [LW-1:0] l2_req_out_line;
   logic l2_rsp_out_valid, l2_rsp_out_ready;
   logic [MW-1:0] l2_rsp_out_coh_msg; logic [IW-1:0] l2_rsp_out_req_id;
   logic l2_rsp_out_to_req;
   logic [AW-1:0] l2_rsp_out_addr;    logic [LW-1:0] l2_rsp_out_line;
   logic l2_rd_rsp_valid, l2_rd_rsp_ready; logic [LW-1:0] l2_rd_rsp_line;
   logic l2_inval_valid, l2_inval_ready;   logic [AW-1:0] l2_inval_addr;
   logic out_idle, overflow_err;

   int checks = 0;
   int errors = 0;

   // Reference model: one queue per channel, plus the sticky overflow flag.
   logic [REQ_W-1:0] q_req[$];
   logic [RSP_W-1:0] q_rsp[$];
   logic [LW-1:0]    q_rd[$];
   logic [AW-1:0]    q_inv[$];
   logic             m_ovf;

   always #5 clk = ~clk;

   l2_output_encoder dut (
      .clk(clk), .rst(rst),
      .send_req(send_req), .send_rsp(send_rsp), .send_rd_rsp(send_rd_rsp), .send_inval(send_inval),
      .req_coh_msg(req_coh_msg), .req_hprot(req_hprot), .req_addr(req_addr), .req_line(req_line),
      .rsp_coh_msg(rsp_coh_msg), .rsp_req_id(rsp_req_id), .rsp_to_req(rsp_to_req),
      .rsp_addr(rsp_addr), .rsp_line(rsp_line),
      .rd_rsp_line(rd_rsp_line), .inval_addr(inval_addr),
      .req_full(req_full), .rsp_full(rsp_full), .rd_rsp_full(rd_rsp_full), .inval_full(inval_full),
      .l2_req_out_valid(l2_req_out_valid), .l2_req_out_ready(l2_req_out_ready),
      .l2_req_out_coh_msg(l2_req_out_coh_msg), .l2_req_out_hprot(l2_req_out_hprot),
      .l2_req_out_addr(l2_req_out_addr), .l2_req_out_line(l2_req_out_line),
      .l2_rsp_out_valid(l2_rsp_out_valid), .l2_rsp_out_ready(l2_rsp_out_ready),
      .l2_rsp_out_coh_msg(l2_rsp_out_coh_msg), .l2_rsp_out_req_id(l2_rsp_out_req_id),
      .l2_rsp_out_to_req(l2_rsp_out_to_req), .l2_rsp_out_addr(l2_rsp_out_addr),
      .l2_rsp_out_line(l2_rsp_out_line),
      .l2_rd_rsp_valid(l2_rd_rsp_valid), .l2_rd_rsp_ready(l2_rd_rsp_ready),
      .l2_rd_rsp_line(l2_rd_rsp_line),
      .l2_inval_valid(l2_inval_valid), .l2_inval_ready(l2_inval_ready),
      .l2_inval_addr(l2_inval_addr),
      .out_idle(out_idle), .overflow_err(overflow_err));

   function automatic logic [LW-1:0] rnd_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare every output against the model's current state.
   task automatic check_all(input string step);
      chk({step, " req_valid"},   200'(l2_req_out_valid), 200'(q_req.size() != 0));
      chk({step, " rsp_valid"},   200'(l2_rsp_out_valid), 200'(q_rsp.size() != 0));
      chk({step, " rd_valid"},    200'(l2_rd_rsp_valid),  200'(q_rd.size()  != 0));
      chk({step, " inval_valid"}, 200'(l2_inval_valid),   200'(q_inv.size() != 0));
      chk({step, " req_full"},    200'(req_full),    200'(q_req.size() == 2));
      chk({step, " rsp_full"},    200'(rsp_full),    200'(q_rsp.size() == 2));
      chk({step, " rd_full"},     200'(rd_rsp_full), 200'(q_rd.size()  == 2));
      chk({step, " inval_full"},  200'(inval_full),  200'(q_inv.size() == 2));
      chk({step, " out_idle"},    200'(out_idle),
          200'(q_req.size() + q_rsp.size() + q_rd.size() + q_inv.size() == 0));
      chk({step, " overflow_err"}, 200'(overflow_err), 200'(m_ovf));
      if (q_req.size() != 0)
         chk({step, " req_payload"}, 200'({l2_req_out_coh_msg, l2_req_out_hprot,
             l2_req_out_addr, l2_req_out_line}), 200'(q_req[0]));
      if (q_rsp.size() != 0)
         chk({step, " rsp_payload"}, 200'({l2_rsp_out_coh_msg, l2_rsp_out_req_id,
             l2_rsp_out_to_req, l2_rsp_out_addr, l2_rsp_out_line}), 200'(q_rsp[0]));
      if (q_rd.size() != 0)
         chk({step, " rd_payload"}, 200'(l2_rd_rsp_line), 200'(q_rd[0]));
      if (q_inv.size() != 0)
         chk({step, " inval_payload"}, 200'(l2_inval_addr), 200'(q_inv[0]));
   endtask

   // Apply the current inputs for one clock: update the model with the
   // channel rules (pop if shown & ready, push if not full beforehand,
   // overflow on a send into a full channel), then check at the falling edge.
   task automatic tick(input string step);
      int n_req, n_rsp, n_rd, n_inv;
      n_req = q_req.size(); n_rsp = q_rsp.size(); n_rd = q_rd.size(); n_inv = q_inv.size();
      if (!rst) begin
         q_req.delete(); q_rsp.delete(); q_rd.delete(); q_inv.delete();
         m_ovf = 1'b0;
      end else begin
         if ((send_req && n_req == 2) || (send_rsp && n_rsp == 2) ||
             (send_rd_rsp && n_rd == 2) || (send_inval && n_inv == 2))
            m_ovf = 1'b1;
         if (l2_req_out_ready && n_req != 0) void'(q_req.pop_front());
         if (l2_rsp_out_ready && n_rsp != 0) void'(q_rsp.pop_front());
         if (l2_rd_rsp_ready  && n_rd  != 0) void'(q_rd.pop_front());
         if (l2_inval_ready   && n_inv != 0) void'(q_inv.pop_front());
         if (send_req && n_req < 2)
            q_req.push_back({req_coh_msg, req_hprot, req_addr, req_line});
         if (send_rsp && n_rsp < 2)
            q_rsp.push_back({rsp_coh_msg, rsp_req_id, rsp_to_req, rsp_addr, rsp_line});
         if (send_rd_rsp && n_rd < 2) q_rd.push_back(rd_rsp_line);
         if (send_inval && n_inv < 2) q_inv.push_back(inval_addr);
      end
      @(posedge clk);
      @(negedge clk);
      check_all(step);
   endtask

   task automatic idle_inputs();
      send_req = 0; send_rsp = 0; send_rd_rsp = 0; send_inval = 0;
   endtask

   task automatic rnd_payloads();
      req_coh_msg = MW'($urandom); req_hprot = 1'($urandom);
      req_addr = AW'($urandom); req_line = rnd_line();
      rsp_coh_msg = MW'($urandom); rsp_req_id = IW'($urandom); rsp_to_req = 1'($urandom);
      rsp_addr = AW'($urandom); rsp_line = rnd_line();
      rd_rsp_line = rnd_line(); inval_addr = AW'($urandom);
   endtask

   initial begin
      m_ovf = 1'b0;
      rst = 1'b0;
      idle_inputs();
      rnd_payloads();
      l2_req_out_ready = 0; l2_rsp_out_ready = 0; l2_rd_rsp_ready = 0; l2_inval_ready = 0;
      @(negedge clk);
      tick("reset0");
      tick("reset1");
      rst = 1'b1;
      tick("post_reset");

      // Single req with ready high: valid one cycle later, then idle again.
      l2_req_out_ready = 1; req_addr = 28'h0ABCDEF; req_coh_msg = 2'd1;
      send_req = 1; tick("req_send");
      send_req = 0; tick("req_drain");
      tick("req_idle");
      l2_req_out_ready = 0;

      // rsp: fill, overflow, then drain in order.
      send_rsp = 1; rsp_addr = 28'h10; tick("rsp_0x10");
      rsp_addr = 28'h20; tick("rsp_0x20");
      rsp_addr = 28'h30; tick("rsp_0x30_drop");
      send_rsp = 0; l2_rsp_out_ready = 1;
      tick("rsp_pop1"); tick("rsp_pop2"); tick("rsp_empty");
      l2_rsp_out_ready = 0;

      // rd_rsp streaming at full rate.
      l2_rd_rsp_ready = 1; send_rd_rsp = 1;
      for (int i = 0; i < 8; i++) begin
         rd_rsp_line = rnd_line();
         tick("rd_stream");
      end
      send_rd_rsp = 0; tick("rd_stream_end");
      l2_rd_rsp_ready = 0;

      // All four channels at once, drained one at a time.
      rnd_payloads();
      send_req = 1; send_rsp = 1; send_rd_rsp = 1; send_inval = 1; tick("all_send");
      idle_inputs();
      l2_req_out_ready = 1; tick("drain_req");
      l2_rsp_out_ready = 1; tick("drain_rsp");
      l2_rd_rsp_ready = 1;  tick("drain_rd");
      l2_inval_ready = 1;   tick("drain_inval");
      l2_req_out_ready = 0; l2_rsp_out_ready = 0; l2_rd_rsp_ready = 0; l2_inval_ready = 0;

      // Fill inval, then reset discards it and clears overflow.
      send_inval = 1; inval_addr = 28'h111; tick("inval_fill1");
      inval_addr = 28'h222; tick("inval_fill2");
      send_inval = 0; rst = 0; tick("mid_reset");
      rst = 1; tick("after_reset");

      // req at count 1: simultaneous push and pop keeps one entry, advances.
      send_req = 1; req_addr = 28'hAAA; tick("req_hold1");
      req_addr = 28'hBBB; l2_req_out_ready = 1; tick("req_push_pop");
      send_req = 0; tick("req_last");
      tick("req_empty");
      l2_req_out_ready = 0;

      // Randomized traffic on all channels.
      for (int i = 0; i < 400; i++) begin
         rnd_payloads();
         send_req = 1'($urandom); send_rsp = 1'($urandom);
         send_rd_rsp = 1'($urandom); send_inval = 1'($urandom);
         l2_req_out_ready = ($urandom_range(3) != 0);
         l2_rsp_out_ready = ($urandom_range(3) == 0);
         l2_rd_rsp_ready  = 1'($urandom);
         l2_inval_ready   = ($urandom_range(7) != 0);
         rst = ($urandom_range(63) != 0);
         tick("random");
         rst = 1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
